fx3_link_arbiter: RTL
=====================

# fx3_link_arbiter

Round-robin arbiter and transaction sequencer that shares the single FX3 GPIO link (transmitter, receiver, FX3 reset line) between up to N_REQ requesters (test engine, USB-status responder, host command path). It sits between the requesters and the transmitter/receiver pair, clocked on the 40 MHz link clock. Each granted request runs one send/receive round trip with an ACK timeout. Timeouts trigger bounded retries and, when retries run out, an FX3 reset pulse followed by an error to the requester.

## Interface
- N_REQ, 3, number of requesters (2..8)
- DATA_W, 23, GPO/GPI word width
- TIMEOUT, 16'h0400, cycles allowed in WAIT_RX before a timeout (≥2)
- RETRY_MAX, 2, retries after the first attempt before escalating to FX3 reset
- RST_CYCLES, 16'h2000, FX3 reset pulse length in cycles (>200 µs at 40 MHz)

Ports:
- clk  in  1  link clock (40 MHz)
- reset_n  in  1  synchronous, active-low reset
- req  in  N_REQ  per-requester request level, held until done/err
- req_data  in  N_REQ*DATA_W  word per requester; slice i = bits [i*DATA_W +: DATA_W]
- grant  out  N_REQ  one-hot owner; high from grant until RELEASE
- done  out  N_REQ  one-cycle pulse: transaction succeeded, rsp_data valid
- err  out  N_REQ  one-cycle pulse: retries exhausted, FX3 was reset
- rsp_data  out  DATA_W  word captured from receiver on success
- tx_data  out  DATA_W  word to transmitter, stable while granted
- tx_start  out  1  = (state == SEND)
- tx_ready  in  1  transmitter finished sending
- tx_hold  out  1  = (state == WAIT_RX); holds transmitter in reset while receiving
- rx_clr  out  1  one-cycle receiver clear before every attempt
- rx_ready  in  1  receiver holds a full word
- rx_data  in  DATA_W  received word
- fx3_rst  out  1  = (state == FX3_RST)

## Operation
- States: IDLE, SEND, WAIT_RX, FX3_RST, RELEASE. All outputs are registered or decoded from the registered state.
- **Reset:** state=IDLE, grant=0, done=0, err=0, rsp_data=0, tx_data=0, rx_clr=0, cnt=0, retries=0, last_idx=N_REQ-1 (requester 0 wins first).
- **IDLE:** when req≠0, pick the first set bit searching from last_idx+1 upward with wrap-around. Register grant=onehot(win), idx=win, tx_data=req_data slice, rx_clr=1, retries=0, then go to SEND.
- **SEND:** rx_clr=0. Stay until tx_ready=1, then cnt=0 and go to WAIT_RX. rx_ready is ignored in this state.
- **WAIT_RX:**
  - rx_ready=1: rsp_data=rx_data, done[idx]=1, go to RELEASE.
  - Else if cnt==TIMEOUT-1 and retries<RETRY_MAX: retries+1, rx_clr=1, go to SEND.
  - Else if cnt==TIMEOUT-1: cnt=0, go to FX3_RST.
  - Else cnt+1.
  - If rx_ready and the timeout occur in the same cycle, rx_ready wins.
- **FX3_RST:** cnt+1. When cnt==RST_CYCLES-1: err[idx]=1, go to RELEASE.
- **RELEASE:** grant=0, last_idx=idx, done/err drop to 0, go to IDLE. req is not sampled in this cycle. A requester must drop req by the cycle after its done/err, or it re-enters arbitration.
- A requester that drops req while granted does not abort the transaction; the result is still pulsed.
- Counters are 16-bit and never wrap: they are cleared on every state entry that uses them.
- reset_n low in any state returns to IDLE next edge, with fx3_rst and tx_start low immediately after that edge.

## Timing
- Minimum latency: req at edge 0 → grant, tx_data, rx_clr at edge 1 → tx_start visible from edge 1.
- With tx_ready at edge k and rx_ready at edge m (m>k): done at edge m+1, grant low at edge m+2, next grant no earlier than edge m+3.
- Timeout: the first retry's rx_clr is asserted TIMEOUT cycles after WAIT_RX entry.
- Worst case per request ≈ (RETRY_MAX+1)·(send+TIMEOUT) + RST_CYCLES + 3 cycles.
- Each done/err pulse lasts exactly one cycle. done and err are never both set. At most one bit is set across all done/err.

## Test plan
- **Single request, no contention:**
  - Stimulus: req=3'b001, data 23'h12345; tx_ready 4 cycles later; rx_ready with 23'h12345 6 cycles after that.
  - Required: grant=001 at edge 1; done[0] one cycle after rx_ready; rsp_data=23'h12345; grant=0 on the following edge.
- **Round robin:**
  - Stimulus: req=3'b111 held, each transaction answered.
  - Required: grant order 001, 010, 100, 001; each requester drops req after its done; no grant is given in any RELEASE cycle.
- **Timeout then success:**
  - Stimulus: TIMEOUT=16, first attempt never answered, second answered.
  - Required: rx_clr pulses twice; tx_start re-asserted at WAIT_RX entry + 16; single done; fx3_rst stays 0.
- **Exhausted retries:**
  - Stimulus: RETRY_MAX=2, no rx_ready ever.
  - Required: three tx_start phases; fx3_rst high exactly RST_CYCLES cycles; then err[idx] pulse; done stays 0.
- **Simultaneous rx_ready and timeout:**
  - Stimulus: rx_ready on the cnt==TIMEOUT-1 cycle.
  - Required: done pulse; no retry; rsp_data captured.
- **Mid-operation reset:**
  - Stimulus: reset_n low during FX3_RST and again during WAIT_RX.
  - Required: next edge shows IDLE with all outputs at reset values; the next grant goes to requester 0.

Source files
------------

// File: rtl/fx3_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fx3_link_arbiter
// Brief    : Round-robin owner of the FX3 GPIO link; one send/receive round
//            trip per grant, with timeout retries and FX3 reset escalation.
// Revision : 1.0 - initial release
// ============================================================================
module fx3_link_arbiter #(
  parameter int          N_REQ      = 3,
  parameter int          DATA_W     = 23,
  parameter logic [15:0] TIMEOUT    = 16'h0400,
  parameter int          RETRY_MAX  = 2,
  parameter logic [15:0] RST_CYCLES = 16'h2000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_ready,
  output logic                    tx_hold,
  output logic                    rx_clr,
  input  logic                    rx_ready,
  input  logic [DATA_W-1:0]       rx_data,
  output logic                    fx3_rst
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_send    = 3'd1;
  localparam logic [2:0] c_st_wait_rx = 3'd2;
  localparam logic [2:0] c_st_fx3_rst = 3'd3;
  localparam logic [2:0] c_st_release = 3'd4;

  localparam logic [15:0]      c_timeout_last = TIMEOUT - 16'd1;
  localparam logic [15:0]      c_rst_last     = RST_CYCLES - 16'd1;
  localparam logic [7:0]       c_retry_max    = 8'(RETRY_MAX);
  localparam logic [IDX_W-1:0] c_idx_last     = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] c_one          = N_REQ'(1);

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_last_idx;
  logic [15:0]      r_cnt;
  logic [7:0]       r_retries;

  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_cand;
  logic [DATA_W-1:0] w_words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_words[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(r_last_idx) + k;
      if (j >= N_REQ) j = j - N_REQ;
      w_cand = IDX_W'(j);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign tx_start = (r_state == c_st_send);
  assign tx_hold  = (r_state == c_st_wait_rx);
  assign fx3_rst  = (r_state == c_st_fx3_rst);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= c_st_idle;
      grant      <= '0;
      done       <= '0;
      err        <= '0;
      rsp_data   <= '0;
      tx_data    <= '0;
      rx_clr     <= 1'b0;
      r_cnt      <= '0;
      r_retries  <= '0;
      r_idx      <= '0;
      r_last_idx <= c_idx_last;
    end else begin
      // done, err and rx_clr are single-cycle pulses raised only on transitions.
      done   <= '0;
      err    <= '0;
      rx_clr <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_found) begin
            grant     <= c_one << w_win;
            r_idx     <= w_win;
            tx_data   <= w_words[w_win];
            rx_clr    <= 1'b1;
            r_retries <= '0;
            r_state   <= c_st_send;
          end
        end
        c_st_send: begin
          if (tx_ready) begin
            r_cnt   <= '0;
            r_state <= c_st_wait_rx;
          end
        end
        c_st_wait_rx: begin
          if (rx_ready) begin
            rsp_data <= rx_data;
            done     <= c_one << r_idx;
            r_state  <= c_st_release;
          end else if (r_cnt == c_timeout_last) begin
            if (r_retries < c_retry_max) begin
              r_retries <= r_retries + 8'd1;
              rx_clr    <= 1'b1;
              r_state   <= c_st_send;
            end else begin
              r_cnt   <= '0;
              r_state <= c_st_fx3_rst;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_st_fx3_rst: begin
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == c_rst_last) begin
            err     <= c_one << r_idx;
            r_state <= c_st_release;
          end
        end
        c_st_release: begin
          grant      <= '0;
          r_last_idx <= r_idx;
          r_state    <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire
